aes_key_sched: RTL and testbench

Parametrised sequential AES key schedule supporting AES-128, AES-192 and AES-256, selected at elaboration time. It replaces the fixed 128-bit, externally sequenced round-key generator.
- Rcon is generated internally.
- Words are expanded one 32-bit word per cycle.
- Round keys are delivered one at a time to the cipher datapath over a valid/ready handshake.
- Sits between the key input register and the round pipeline of the encryption core.

---
 rtl/aes_key_sched_pkg.sv | 69 ++++++
 rtl/aes_key_sched_subword.sv | 21 ++
 rtl/aes_key_sched.sv | 182 ++++++++++++++++++
 tb/tb_aes_key_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_pkg
// Description : Shared AES types, key-length constants, GF(2^8) helpers
//               (xtime, multiply, S-box) and key-schedule FSM encoding.
// Revision    : 1.0 - initial parametrised key schedule release
// ============================================================================
package aes_key_sched_pkg;

    typedef logic [7:0]   aes_byte;
    typedef logic [31:0]  aes_32;
    typedef logic [127:0] aes_128;

    localparam int AES_KEY_128 = 128;
    localparam int AES_KEY_192 = 192;
    localparam int AES_KEY_256 = 256;

    // Key-schedule FSM encoding
    typedef logic [1:0] aes_state_t;
    localparam aes_state_t ST_IDLE = 2'd0;
    localparam aes_state_t ST_GEN  = 2'd1;
    localparam aes_state_t ST_OUT  = 2'd2;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B)
    function automatic aes_byte xtime(input aes_byte a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte gf_mul(input aes_byte a, input aes_byte b);
        aes_byte p;
        aes_byte t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box computed arithmetically: multiplicative inverse (a^254, with
    // 0 mapping to 0) followed by the FIPS-197 affine transform.
    function automatic aes_byte sbox(input aes_byte a);
        aes_byte sq;
        aes_byte inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);   // a^(2^k)
            inv = gf_mul(inv, sq);  // product over k=1..7 gives a^254
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_subword.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_subword
// Description : SubWord - four parallel combinational S-box lookups.
//   i_word [31:0] : input word
//   o_word [31:0] : byte-wise substituted word
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_subword
    import aes_key_sched_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched
// Description : Sequential AES-128/192/256 key schedule. Expands one 32-bit
//               word per cycle from a sliding window of the last NK words and
//               hands out each 128-bit round key over a valid/ready handshake.
//   clk, nrst           : clock, asynchronous active-low reset
//   start, abort        : begin expansion (when idle) / cancel to idle
//   key_i [KEY_BITS]    : cipher key, MSW = w[0]
//   rk_o [128]          : round key {w[4r], .., w[4r+3]}
//   rk_valid / rk_ready : round-key handshake
//   rk_idx [4], rk_last : round index and final-round flag
//   busy                : expansion in progress
// Build option: AES_KEY_SCHED_ZEROIZE_EN clears key material on return to
//               idle (final handshake or abort).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module aes_key_sched
    import aes_key_sched_pkg::*;
#(
    parameter int KEY_BITS = 128
)
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                abort,
    input  logic [KEY_BITS-1:0] key_i,
    output logic [127:0]        rk_o,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [3:0]          rk_idx,
    output logic                rk_last,
    output logic                busy
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam logic [5:0] c_nk   = 6'(NK);
    localparam logic [2:0] c_kmax = 3'(NK - 1);
    localparam logic [3:0] c_nr   = 4'(NR);

    if (KEY_BITS != AES_KEY_128 && KEY_BITS != AES_KEY_192 &&
        KEY_BITS != AES_KEY_256) begin : g_bad_key_bits
        $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_t          r_state;
    logic [KEY_BITS-1:0] r_key;
    aes_32               r_win [NK];   // r_win[NK-1] = w[i-1], r_win[0] = w[i-NK]
    aes_32               r_acc [3];    // first three words of the current round
    logic [5:0]          r_cnt;        // word index i
    logic [2:0]          r_kpos;       // i mod NK
    logic [1:0]          r_wpos;       // word position within the round key
    logic [3:0]          r_round;
    aes_byte             r_rcon;
    aes_128              r_rk;
    logic [3:0]          r_idx;
    logic                r_last;

    aes_32 w_key_words [8];
    aes_32 w_prev;
    aes_32 w_sub_in;
    aes_32 w_sub_out;
    aes_32 w_temp;
    aes_32 w_word;

    // Fixed-size table of key words so the 3-bit position indexes it cleanly
    for (genvar j = 0; j < 8; j++) begin : g_key_words
        if (j < NK) begin : g_used
            assign w_key_words[j] = r_key[KEY_BITS-1-32*j -: 32];
        end else begin : g_unused
            assign w_key_words[j] = '0;
        end
    end

    assign w_prev = r_win[NK-1];

    // One S-box bank serves both SubWord cases; RotWord only on the i mod NK = 0 path
    assign w_sub_in = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_key_sched_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_kpos == 3'd0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h0};
        end else if (NK == 8 && r_kpos == 3'd4) begin
            w_temp = w_sub_out;
        end
        w_word = (r_cnt < c_nk) ? w_key_words[r_kpos] : (r_win[0] ^ w_temp);
    end

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic w_to_idle;
    assign w_to_idle = abort || (r_state == ST_OUT && rk_ready && r_last);
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            for (int j = 0; j < NK; j++) r_win[j] <= '0;
            for (int j = 0; j < 3; j++)  r_acc[j] <= '0;
            r_cnt   <= '0;
            r_kpos  <= '0;
            r_wpos  <= '0;
            r_round <= '0;
            r_rcon  <= 8'h01;
            r_rk    <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_key   <= key_i;
                            r_cnt   <= '0;
                            r_kpos  <= '0;
                            r_wpos  <= '0;
                            r_round <= '0;
                            r_rcon  <= 8'h01;
                            r_state <= ST_GEN;
                        end
                    end
                    ST_GEN: begin
                        for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
                        r_win[NK-1] <= w_word;
                        r_cnt  <= r_cnt + 6'd1;
                        r_kpos <= (r_kpos == c_kmax) ? 3'd0 : r_kpos + 3'd1;
                        r_wpos <= r_wpos + 2'd1;
                        if (r_cnt >= c_nk && r_kpos == 3'd0) begin
                            r_rcon <= xtime(r_rcon);
                        end
                        if (r_wpos == 2'd3) begin
                            r_rk    <= {r_acc[0], r_acc[1], r_acc[2], w_word};
                            r_idx   <= r_round;
                            r_last  <= (r_round == c_nr);
                            r_state <= ST_OUT;
                        end else begin
                            r_acc[r_wpos] <= w_word;
                        end
                    end
                    ST_OUT: begin
                        if (rk_ready) begin
                            if (r_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_round <= r_round + 4'd1;
                                r_state <= ST_GEN;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
`ifdef AES_KEY_SCHED_ZEROIZE_EN
            if (w_to_idle) begin
                r_key <= '0;
                for (int j = 0; j < NK; j++) r_win[j] <= '0;
                for (int j = 0; j < 3; j++)  r_acc[j] <= '0;
                r_rk  <= '0;
                r_idx <= '0;
            end
`endif
        end
    end

    assign rk_o     = r_rk;
    assign rk_idx   = r_idx;
    assign rk_valid = (r_state == ST_OUT);
    assign rk_last  = r_last && rk_valid;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched
// Description : Self-checking bench for aes_key_sched (128/192/256 instances)
//               against a table-driven FIPS-197 key expansion model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start    [3];
    logic         abort    [3];
    logic [255:0] key_bus  [3];
    logic [127:0] rk_o     [3];
    logic         rk_valid [3];
    logic         rk_ready [3];
    logic [3:0]   rk_idx   [3];
    logic         rk_last  [3];
    logic         busy     [3];

    int errors = 0;
    int checks = 0;
    logic [31:0]  ref_w [60];
    logic [127:0] got   [15];

    always #5 clk = ~clk;

    aes_key_sched #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .nrst(nrst), .start(start[0]), .abort(abort[0]),
        .key_i(key_bus[0][127:0]), .rk_o(rk_o[0]), .rk_valid(rk_valid[0]),
        .rk_ready(rk_ready[0]), .rk_idx(rk_idx[0]), .rk_last(rk_last[0]), .busy(busy[0]));
    aes_key_sched #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .nrst(nrst), .start(start[1]), .abort(abort[1]),
        .key_i(key_bus[1][191:0]), .rk_o(rk_o[1]), .rk_valid(rk_valid[1]),
        .rk_ready(rk_ready[1]), .rk_idx(rk_idx[1]), .rk_last(rk_last[1]), .busy(busy[1]));
    aes_key_sched #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .nrst(nrst), .start(start[2]), .abort(abort[2]),
        .key_i(key_bus[2]), .rk_o(rk_o[2]), .rk_valid(rk_valid[2]),
        .rk_ready(rk_ready[2]), .rk_idx(rk_idx[2]), .rk_last(rk_last[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // FIPS-197 key expansion; the key occupies the low nk*32 bits of 'key'
    task automatic build_ref(input logic [255:0] key, input int nk);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) ref_w[i] = key[(nk - i) * 32 - 1 -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i / nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = sub_word(t);
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    // Full expansion on instance k; last_cyc > 0 enables cycle-exact checks
    task automatic run_keys(input int k, input logic [255:0] key, input bit rnd,
                            input int last_cyc, input bit poke);
        int nk, nr, cnt, cyc, first_cyc, last_seen;
        logic [127:0] held;
        bit stalled;
        nk = 4 + 2 * k;
        nr = nk + 6;
        build_ref(key, nk);
        @(negedge clk);
        key_bus[k] = key;
        start[k] = 1'b1;
        rk_ready[k] = 1'b1;
        cnt = 0; cyc = 0; stalled = 0; first_cyc = -1; last_seen = -1; held = '0;
        while (cnt < nr + 1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start[k] = 1'b0;
            if (cyc == 1) check("busy_rise", 128'(busy[k]), 128'(1));
            if (poke && cyc == 7) begin
                start[k] = 1'b1;
                key_bus[k] = ~key;
            end
            if (rk_valid[k]) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled) check("rk_stable", rk_o[k], held);
                rk_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rk_ready[k]) begin
                    check($sformatf("rk%0d_k%0d", cnt, k), rk_o[k], ref_rk(cnt));
                    check("rk_idx", 128'(rk_idx[k]), 128'(cnt));
                    check("rk_last", 128'(rk_last[k]), 128'(cnt == nr));
                    if (cnt < 15) got[cnt] = rk_o[k];
                    if (cnt == nr) last_seen = cyc;
                    cnt++;
                    stalled = 0;
                end else begin
                    held = rk_o[k];
                    stalled = 1;
                end
            end else begin
                rk_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        check("handshakes", 128'(cnt), 128'(nr + 1));
        if (last_cyc > 0) begin
            check("first_valid_cycle", 128'(first_cyc), 128'(5));
            check("last_key_cycle", 128'(last_seen), 128'(last_cyc));
        end
        @(negedge clk);
        start[k] = 1'b0;
        key_bus[k] = key;
        check("busy_done", 128'(busy[k]), 128'(0));
        check("valid_done", 128'(rk_valid[k]), 128'(0));
        rk_ready[k] = 1'b1;
    endtask

    initial begin
        logic [255:0] key128, key192, key256, rkey;
        key128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        key192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; rk_ready[k] = 1'b1; key_bus[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_rk_o", rk_o[0], 128'h0);
        check("rst_valid", 128'(rk_valid[0]), 128'(0));
        check("rst_idx", 128'(rk_idx[0]), 128'(0));
        check("rst_last", 128'(rk_last[0]), 128'(0));
        check("rst_busy", 128'(busy[2]), 128'(0));
        nrst = 1'b1;

        // Known-answer runs with rk_ready tied high
        run_keys(0, key128, 1'b0, 55, 1'b0);
        check("kat128_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("kat128_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_keys(1, key192, 1'b0, 65, 1'b0);
        check("kat192_r12", got[12], 128'he98ba06f448c773c8ecc720401002202);
        run_keys(2, key256, 1'b0, 75, 1'b0);
        check("kat256_r14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Random keys, random backpressure, start poked while busy
        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_keys(0, {128'h0, rkey[127:0]}, 1'b1, -1, n == 1);
        end
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_keys(2, rkey, 1'b1, -1, 1'b1);
        run_keys(1, {64'h0, rkey[191:0]}, 1'b0, 65, 1'b1);

        // Abort in GEN of round 3, then restart with the same key
        build_ref(key128, 4);
        @(negedge clk);
        key_bus[0] = key128; start[0] = 1'b1; rk_ready[0] = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("abort_busy", 128'(busy[0]), 128'(0));
        check("abort_valid", 128'(rk_valid[0]), 128'(0));
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        check("abort_rk_zero", rk_o[0], 128'h0);
`else
        check("abort_rk_hold", rk_o[0], ref_rk(2));
`endif
        run_keys(0, key128, 1'b0, 55, 1'b0);

        // Simultaneous start and abort: abort wins
        @(negedge clk);
        start[0] = 1'b1; abort[0] = 1'b1; key_bus[0] = {128'h0, 128'h0123456789abcdef0011223344556677};
        @(negedge clk);
        start[0] = 1'b0; abort[0] = 1'b0;
        check("start_abort_busy", 128'(busy[0]), 128'(0));
        repeat (5) @(negedge clk);
        check("start_abort_valid", 128'(rk_valid[0]), 128'(0));

        // Asynchronous reset mid-run
        @(negedge clk);
        key_bus[0] = key128; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (11) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("arst_rk_o", rk_o[0], 128'h0);
        check("arst_valid", 128'(rk_valid[0]), 128'(0));
        check("arst_idx", 128'(rk_idx[0]), 128'(0));
        check("arst_busy", 128'(busy[0]), 128'(0));
        @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_no_resume", 128'(busy[0]), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
